alu_muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer that implements 32x32 unsigned multiply and divide (HI/LO results) by iterating on the existing ALU.
- Drives the ALU's cmd/a/b inputs and consumes its registered out, one ALU operation per iteration.
- Sits beside the ALU in the MIPS core; the control unit issues a request and waits for done.
- The ALU itself is unchanged; its overflow and zero outputs are unused here.

---
 rtl/alu_muldiv_sequencer_pkg.sv | 63 ++++++
 rtl/alu_muldiv_sequencer_if.sv | 40 ++++
 rtl/alu_muldiv_sequencer_step.sv | 63 ++++++
 rtl/alu_muldiv_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : Types / ALUType / MulDivType packages
// Brief  : Shared register, ALU command and mul/div sequencer types.
//          ALU_MULDIV_SIGNED_EN adds signed MULT/DIV and the FIXUP state.
// Rev    : 1.0
// ============================================================================

package Types;
   typedef logic [31:0] reg_t;
endpackage

package ALUType;
   typedef enum logic [2:0] {
      ADD  = 3'd0,
      SUB  = 3'd1,
      AND  = 3'd2,
      OR   = 3'd3,
      XOR  = 3'd4,
      NOR  = 3'd5,
      SLT  = 3'd6,
      SLTU = 3'd7
   } cmd_t;
endpackage

package MulDivType;
   localparam int MULDIV_ITERS = 32;

   typedef enum logic [1:0] {
      MULTU = 2'd0,
      DIVU  = 2'd1
`ifdef ALU_MULDIV_SIGNED_EN
      , MULT = 2'd2
      , DIV  = 2'd3
`endif
   } op_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      CAPTURE = 3'd2,
      DONE    = 3'd3
`ifdef ALU_MULDIV_SIGNED_EN
      , FIXUP = 3'd4
`endif
   } state_t;

   function automatic logic is_div_op(input op_t op);
`ifdef ALU_MULDIV_SIGNED_EN
      return (op == DIVU) || (op == DIV);
`else
      return (op == DIVU);
`endif
   endfunction

`ifdef ALU_MULDIV_SIGNED_EN
   function automatic logic is_signed_op(input op_t op);
      return (op == MULT) || (op == DIV);
   endfunction
`endif
endpackage

`default_nettype wire

// File: rtl/alu_muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : alu_muldiv_sequencer_if
// Brief  : Request/result handshake plus ALU operand/result bus.
// Rev    : 1.0
// ============================================================================

interface alu_muldiv_sequencer_if;
   import Types::*;
   import ALUType::*;
   import MulDivType::*;

   logic req_valid;
   logic req_ready;
   op_t  req_op;
   reg_t opnd_a;
   reg_t opnd_b;
   logic busy;
   logic done;
   logic div_by_zero;
   reg_t hi;
   reg_t lo;
   cmd_t alu_cmd;
   reg_t alu_a;
   reg_t alu_b;
   reg_t alu_out;

   // slave: the sequencer; master: control unit together with the ALU
   modport slave (
      input  req_valid, req_op, opnd_a, opnd_b, alu_out,
      output req_ready, busy, done, div_by_zero, hi, lo, alu_cmd, alu_a, alu_b
   );

   modport master (
      output req_valid, req_op, opnd_a, opnd_b, alu_out,
      input  req_ready, busy, done, div_by_zero, hi, lo, alu_cmd, alu_a, alu_b
   );
endinterface

`default_nettype wire

// File: rtl/alu_muldiv_sequencer_step.sv
`default_nettype none
// ============================================================================
// Module : alu_muldiv_step
// Brief  : One shift-add / restoring-divide step around the shared ALU.
// Rev    : 1.0
// ============================================================================

module alu_muldiv_step
   import Types::*;
   import ALUType::*;
(
   input  logic i_is_div,
   input  logic i_issue,
   input  reg_t i_hi,
   input  reg_t i_lo,
   input  logic i_msb,
   input  reg_t i_oper,
   input  reg_t i_alu_out,
   output reg_t o_hi_nxt,
   output reg_t o_lo_nxt,
   output cmd_t o_alu_cmd,
   output reg_t o_alu_a,
   output reg_t o_alu_b
);
   reg_t w_shift;
   logic w_carry;
   logic w_borrow;
   logic w_take;

   assign w_shift  = {i_hi[30:0], i_lo[31]};
   assign w_carry  = (i_alu_out < i_hi);
   assign w_borrow = (i_alu_out > i_hi);
   // A set msb means the shifted remainder exceeded 32 bits, so it always beats the divisor
   assign w_take   = i_msb | ~w_borrow;

   always_comb begin
      o_hi_nxt  = i_hi;
      o_lo_nxt  = i_lo;
      o_alu_cmd = ADD;
      o_alu_a   = '0;
      o_alu_b   = '0;
      if (i_issue) begin
         if (i_is_div) begin
            o_alu_cmd = SUB;
            o_alu_a   = w_shift;
            o_alu_b   = i_oper;
            o_hi_nxt  = w_shift;
         end else begin
            o_alu_cmd = ADD;
            o_alu_a   = i_hi;
            o_alu_b   = i_lo[0] ? i_oper : '0;
         end
      end else if (i_is_div) begin
         o_hi_nxt = w_take ? i_alu_out : i_hi;
         o_lo_nxt = {i_lo[30:0], w_take};
      end else begin
         o_hi_nxt = {w_carry, i_alu_out[31:1]};
         o_lo_nxt = {i_alu_out[0], i_lo[31:1]};
      end
   end
endmodule

`default_nettype wire

// File: rtl/alu_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module : alu_muldiv_sequencer
// Brief  : 32x32 multiply/divide sequencer iterating on the shared ALU.
//          ALU_MULDIV_SIGNED_EN adds signed MULT/DIV with a FIXUP state.
// Rev    : 1.0
// ============================================================================

module alu_muldiv_sequencer
   import Types::*;
   import ALUType::*;
   import MulDivType::*;
#(
   parameter int ITERS = MULDIV_ITERS
) (
   input  logic                   clk,
   input  logic                   rst,
   alu_muldiv_sequencer_if.slave  bus
);
   localparam logic [5:0] c_LAST_ITER = 6'(ITERS - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic       w_accept;
   logic       w_div_req;
   logic       w_zero_div;
   logic       w_issue;
   logic       w_req_ready;
   logic       w_busy;
   logic       w_done;
   reg_t       r_hi;
   reg_t       r_lo;
   reg_t       r_oper;
   logic       r_msb;
   logic       r_is_div;
   logic       r_dbz;
   logic [5:0] r_cnt;
   reg_t       w_hi_nxt;
   reg_t       w_lo_nxt;
   reg_t       w_mag_a;
   reg_t       w_mag_b;
   cmd_t       w_alu_cmd;
   reg_t       w_alu_a;
   reg_t       w_alu_b;

   assign w_div_req  = is_div_op(bus.req_op);
   assign w_zero_div = w_div_req && (bus.opnd_b == '0);
   assign w_issue    = (r_state == ISSUE);

`ifdef ALU_MULDIV_SIGNED_EN
   logic w_sign_a;
   logic w_sign_b;
   logic r_sa;
   logic r_sb;

   assign w_sign_a = is_signed_op(bus.req_op) && bus.opnd_a[31];
   assign w_sign_b = is_signed_op(bus.req_op) && bus.opnd_b[31];
   assign w_mag_a  = w_sign_a ? -bus.opnd_a : bus.opnd_a;
   assign w_mag_b  = w_sign_b ? -bus.opnd_b : bus.opnd_b;
`else
   assign w_mag_a  = bus.opnd_a;
   assign w_mag_b  = bus.opnd_b;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_req_ready = 1'b0;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            w_req_ready = 1'b1;
            w_busy      = 1'b0;
            if (bus.req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = w_zero_div ? DONE : ISSUE;
            end
         end
         ISSUE: w_state_nxt = CAPTURE;
         CAPTURE: begin
            if (r_cnt < c_LAST_ITER) begin
               w_state_nxt = ISSUE;
            end else begin
`ifdef ALU_MULDIV_SIGNED_EN
               w_state_nxt = FIXUP;
`else
               w_state_nxt = DONE;
`endif
            end
         end
`ifdef ALU_MULDIV_SIGNED_EN
         FIXUP: w_state_nxt = DONE;
`endif
         DONE: begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   alu_muldiv_step u_step (
      .i_is_div  (r_is_div),
      .i_issue   (w_issue),
      .i_hi      (r_hi),
      .i_lo      (r_lo),
      .i_msb     (r_msb),
      .i_oper    (r_oper),
      .i_alu_out (bus.alu_out),
      .o_hi_nxt  (w_hi_nxt),
      .o_lo_nxt  (w_lo_nxt),
      .o_alu_cmd (w_alu_cmd),
      .o_alu_a   (w_alu_a),
      .o_alu_b   (w_alu_b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi     <= '0;
         r_lo     <= '0;
         r_oper   <= '0;
         r_msb    <= 1'b0;
         r_is_div <= 1'b0;
         r_dbz    <= 1'b0;
         r_cnt    <= '0;
`ifdef ALU_MULDIV_SIGNED_EN
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_cnt    <= '0;
                  r_is_div <= w_div_req;
                  r_dbz    <= w_zero_div;
`ifdef ALU_MULDIV_SIGNED_EN
                  r_sa     <= w_sign_a;
                  r_sb     <= w_sign_b;
`endif
                  if (w_zero_div) begin
                     r_hi <= bus.opnd_a;
                     r_lo <= '1;
                  end else begin
                     r_hi   <= '0;
                     r_lo   <= w_div_req ? w_mag_a : w_mag_b;
                     r_oper <= w_div_req ? w_mag_b : w_mag_a;
                  end
               end
            end
            ISSUE: begin
               r_msb <= r_hi[31];
               r_hi  <= w_hi_nxt;
               r_lo  <= w_lo_nxt;
            end
            CAPTURE: begin
               r_hi  <= w_hi_nxt;
               r_lo  <= w_lo_nxt;
               r_cnt <= r_cnt + 6'd1;
            end
`ifdef ALU_MULDIV_SIGNED_EN
            FIXUP: begin
               if (!r_is_div) begin
                  if (r_sa ^ r_sb) {r_hi, r_lo} <= -{r_hi, r_lo};
               end else begin
                  // Remainder takes the dividend's sign, quotient the XOR of both
                  if (r_sa ^ r_sb) r_lo <= -r_lo;
                  if (r_sa)        r_hi <= -r_hi;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.req_ready   = w_req_ready;
   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.div_by_zero = r_dbz;
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;
   assign bus.alu_cmd     = w_alu_cmd;
   assign bus.alu_a       = w_alu_a;
   assign bus.alu_b       = w_alu_b;
endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_muldiv_sequencer
// Brief  : Scoreboard bench for the mul/div sequencer with a registered ALU model.
// Rev    : 1.0
// ============================================================================

module tb_alu_muldiv_sequencer;
   import Types::*;
   import ALUType::*;
   import MulDivType::*;

`ifdef ALU_MULDIV_SIGNED_EN
   localparam int LAT = 66;
`else
   localparam int LAT = 65;
`endif

   typedef struct {
      reg_t hi;
      reg_t lo;
      logic dbz;
      int   lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   alu_muldiv_sequencer_if bus();

   alu_muldiv_sequencer #(.ITERS(MULDIV_ITERS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Registered ALU: result visible the cycle after the operands are driven
   always @(posedge clk) begin
      case (bus.alu_cmd)
         ADD:     bus.alu_out <= bus.alu_a + bus.alu_b;
         SUB:     bus.alu_out <= bus.alu_a - bus.alu_b;
         default: bus.alu_out <= 32'hDEAD_BEEF;
      endcase
   end

   function automatic exp_t model(input op_t op, input reg_t a, input reg_t b);
      exp_t e;
      logic [63:0] p;
`ifdef ALU_MULDIV_SIGNED_EN
      logic signed [31:0] sa;
      logic signed [31:0] sbv;
      sa  = a;
      sbv = b;
`endif
      e.dbz = 1'b0;
      e.lat = LAT;
      e.hi  = '0;
      e.lo  = '0;
      if (is_div_op(op) && b == 32'd0) begin
         e.hi  = a;
         e.lo  = 32'hFFFF_FFFF;
         e.dbz = 1'b1;
         e.lat = 1;
      end else begin
         case (op)
            MULTU: begin
               p = {32'd0, a} * {32'd0, b};
               e.hi = p[63:32];
               e.lo = p[31:0];
            end
            DIVU: begin
               e.lo = a / b;
               e.hi = a % b;
            end
`ifdef ALU_MULDIV_SIGNED_EN
            MULT: begin
               p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
               e.hi = p[63:32];
               e.lo = p[31:0];
            end
            DIV: begin
               e.lo = sa / sbv;
               e.hi = sa % sbv;
            end
`endif
            default: ;
         endcase
      end
      return e;
   endfunction

   // Starts at a negedge in an IDLE cycle, ends at the negedge of cycle T+1
   task automatic start_op(input op_t op, input reg_t a, input reg_t b, input bit hold);
      bus.req_op    = op;
      bus.opnd_a    = a;
      bus.opnd_b    = b;
      bus.req_valid = 1'b1;
      sb_q.push_back(model(op, a, b));
      @(posedge clk);
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
   endtask

   // Ends at the negedge of the DONE cycle; lat counts cycles after accept
   task automatic wait_done(output int lat, output bit window_ok);
      lat       = 1;
      window_ok = 1'b1;
      while (bus.done !== 1'b1 && lat < 200) begin
         if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) window_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) window_ok = 1'b0;
      if (bus.done !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL done_timeout: done=%b after %0d cycles, required done=1", bus.done, lat);
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = MULTU;
      bus.opnd_a    = '0;
      bus.opnd_b    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_handshake: ready=%b busy=%b, required ready=1 busy=0", bus.req_ready, bus.busy);
      end
      total++;
      if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags: done=%b dbz=%b, required 0 0", bus.done, bus.div_by_zero);
      end
      total++;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         bad++;
         $display("FAIL reset_result: hi=%h lo=%h, required 0 0", bus.hi, bus.lo);
      end
      total++;
      if (bus.alu_cmd !== ADD || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
         bad++;
         $display("FAIL reset_alu_drive: cmd=%0d a=%h b=%h, required ADD 0 0", bus.alu_cmd, bus.alu_a, bus.alu_b);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_multu();
      reg_t ta[5];
      reg_t tb[5];
      int   lat;
      bit   wok;
      exp_t e;
      ta = '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'h1234_5678};
      tb = '{32'd6, 32'hFFFF_FFFF, 32'hABCD_0123, 32'd2, 32'h9ABC_DEF0};
      for (int i = 0; i < 8; i++) begin
         if (i < 5) start_op(MULTU, ta[i], tb[i], 1'b0);
         else       start_op(MULTU, $urandom(), $urandom(), 1'b0);
         wait_done(lat, wok);
         e = sb_q.pop_front();
         total++;
         if (lat != e.lat || !wok || bus.hi !== e.hi || bus.lo !== e.lo || bus.div_by_zero !== e.dbz) begin
            bad++;
            $display("FAIL multu[%0d]: hi=%h lo=%h dbz=%b lat=%0d window=%0b, required hi=%h lo=%h dbz=%b lat=%0d window=1",
                     i, bus.hi, bus.lo, bus.div_by_zero, lat, wok, e.hi, e.lo, e.dbz, e.lat);
         end
         @(negedge clk);
         total++;
         if (bus.done !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL multu_after_done[%0d]: done=%b ready=%b busy=%b, required 0 1 0",
                     i, bus.done, bus.req_ready, bus.busy);
         end
      end
   endtask

   task automatic test_divu();
      reg_t ta[6];
      reg_t tb[6];
      int   lat;
      bit   wok;
      exp_t e;
      ta = '{32'd100, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
      tb = '{32'd7,   32'd1,         32'd9, 32'hC000_0001, 32'd3,         32'h8000_0000};
      for (int i = 0; i < 10; i++) begin
         if (i < 6)      start_op(DIVU, ta[i], tb[i], 1'b0);
         else if (i < 8) start_op(DIVU, $urandom(), 32'($urandom_range(1, 1000)), 1'b0);
         else            start_op(DIVU, $urandom(), $urandom() | 32'h8000_0000, 1'b0);
         wait_done(lat, wok);
         e = sb_q.pop_front();
         total++;
         if (lat != e.lat || !wok || bus.hi !== e.hi || bus.lo !== e.lo || bus.div_by_zero !== e.dbz) begin
            bad++;
            $display("FAIL divu[%0d]: hi=%h lo=%h dbz=%b lat=%0d window=%0b, required hi=%h lo=%h dbz=%b lat=%0d window=1",
                     i, bus.hi, bus.lo, bus.div_by_zero, lat, wok, e.hi, e.lo, e.dbz, e.lat);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_div_by_zero();
      int   lat;
      bit   wok;
      exp_t e;
      start_op(DIVU, 32'd1234, 32'd0, 1'b0);
      wait_done(lat, wok);
      e = sb_q.pop_front();
      total++;
      if (lat != 1 || !wok) begin
         bad++;
         $display("FAIL dbz_latency: lat=%0d window=%0b, required lat=1 window=1", lat, wok);
      end
      total++;
      if (bus.div_by_zero !== 1'b1) begin
         bad++;
         $display("FAIL dbz_flag: dbz=%b, required 1", bus.div_by_zero);
      end
      total++;
      if (bus.hi !== e.hi || bus.lo !== e.lo) begin
         bad++;
         $display("FAIL dbz_result: hi=%h lo=%h, required hi=%h lo=%h", bus.hi, bus.lo, e.hi, e.lo);
      end
      @(negedge clk);
      start_op(DIVU, 32'd9, 32'd3, 1'b0);
      wait_done(lat, wok);
      e = sb_q.pop_front();
      total++;
      if (lat != e.lat || bus.div_by_zero !== 1'b0 || bus.hi !== e.hi || bus.lo !== e.lo) begin
         bad++;
         $display("FAIL dbz_followup: hi=%h lo=%h dbz=%b lat=%0d, required hi=%h lo=%h dbz=0 lat=%0d",
                  bus.hi, bus.lo, bus.div_by_zero, lat, e.hi, e.lo, e.lat);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int   lat;
      bit   wok;
      exp_t e;
      start_op(MULTU, 32'h0001_0003, 32'h0000_0101, 1'b1);
      bus.req_op = DIVU;
      bus.opnd_a = 32'd1000;
      bus.opnd_b = 32'd33;
      sb_q.push_back(model(DIVU, 32'd1000, 32'd33));
      wait_done(lat, wok);
      e = sb_q.pop_front();
      total++;
      if (lat != e.lat || !wok || bus.hi !== e.hi || bus.lo !== e.lo) begin
         bad++;
         $display("FAIL b2b_first: hi=%h lo=%h lat=%0d window=%0b, required hi=%h lo=%h lat=%0d window=1",
                  bus.hi, bus.lo, lat, wok, e.hi, e.lo, e.lat);
      end
      @(negedge clk);
      total++;
      if (bus.req_ready !== 1'b1 || bus.hi !== e.hi || bus.lo !== e.lo) begin
         bad++;
         $display("FAIL b2b_hold: ready=%b hi=%h lo=%h, required ready=1 hi=%h lo=%h",
                  bus.req_ready, bus.hi, bus.lo, e.hi, e.lo);
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      wait_done(lat, wok);
      e = sb_q.pop_front();
      total++;
      if (lat != e.lat || !wok || bus.hi !== e.hi || bus.lo !== e.lo || bus.div_by_zero !== 1'b0) begin
         bad++;
         $display("FAIL b2b_second: hi=%h lo=%h dbz=%b lat=%0d, required hi=%h lo=%h dbz=0 lat=%0d",
                  bus.hi, bus.lo, bus.div_by_zero, lat, e.hi, e.lo, e.lat);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      int   lat;
      bit   wok;
      exp_t e;
      start_op(MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sb_q.pop_front());
      total++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         bad++;
         $display("FAIL midreset_state: ready=%b busy=%b done=%b, required 1 0 0", bus.req_ready, bus.busy, bus.done);
      end
      total++;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         bad++;
         $display("FAIL midreset_result: hi=%h lo=%h, required 0 0", bus.hi, bus.lo);
      end
      start_op(MULTU, 32'd3, 32'd5, 1'b0);
      wait_done(lat, wok);
      e = sb_q.pop_front();
      total++;
      if (lat != e.lat || !wok || bus.hi !== e.hi || bus.lo !== e.lo) begin
         bad++;
         $display("FAIL midreset_fresh: hi=%h lo=%h lat=%0d, required hi=%h lo=%h lat=%0d",
                  bus.hi, bus.lo, lat, e.hi, e.lo, e.lat);
      end
      @(negedge clk);
   endtask

`ifdef ALU_MULDIV_SIGNED_EN
   task automatic test_signed();
      op_t  to[8];
      reg_t ta[8];
      reg_t tb[8];
      int   lat;
      bit   wok;
      exp_t e;
      to = '{MULT, DIV, DIV, DIV, MULT, MULT, DIV, MULTU};
      ta = '{-32'sd3, -32'sd7, 32'd7, -32'sd7, -32'sd4, 32'h8000_0000, -32'sd5, 32'hFFFF_FFFF};
      tb = '{32'd5, 32'd2, -32'sd2, -32'sd2, -32'sd6, 32'd3, 32'd0, 32'd2};
      for (int i = 0; i < 8; i++) begin
         start_op(to[i], ta[i], tb[i], 1'b0);
         wait_done(lat, wok);
         e = sb_q.pop_front();
         total++;
         if (lat != e.lat || !wok || bus.hi !== e.hi || bus.lo !== e.lo || bus.div_by_zero !== e.dbz) begin
            bad++;
            $display("FAIL signed[%0d]: hi=%h lo=%h dbz=%b lat=%0d window=%0b, required hi=%h lo=%h dbz=%b lat=%0d window=1",
                     i, bus.hi, bus.lo, bus.div_by_zero, lat, wok, e.hi, e.lo, e.dbz, e.lat);
         end
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_multu();
      test_divu();
      test_div_by_zero();
      test_back_to_back();
      test_reset_mid_op();
`ifdef ALU_MULDIV_SIGNED_EN
      test_signed();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
